// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait freeze,
// plus a memory-timeout watchdog and saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned COUNTER_WIDTH  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     exMemoryReadEnable,
  input  logic                     exRegisterWriteEnable,
  input  logic [4:0]               exRd,
  input  logic [4:0]               idRs1,
  input  logic [4:0]               idRs2,
  input  logic                     idUsesRs1,
  input  logic                     idUsesRs2,
  input  logic                     branchTaken,
  input  logic                     memRequest,
  input  logic                     dataMemoryReady,
  output logic                     pcWriteEnable,
  output logic                     ifIdWriteEnable,
  output logic                     ifIdFlush,
  output logic                     idExWriteEnable,
  output logic                     idExFlush,
  output logic                     exMemWriteEnable,
  output logic                     memWbWriteEnable,
  output logic                     memoryTimeout,
  output logic [COUNTER_WIDTH-1:0] stallCycles,
  output logic [COUNTER_WIDTH-1:0] flushCount
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

  state_e                   state_q, state_d;
  logic [WAIT_W-1:0]        waitCount_q, waitCount_d;
  logic [COUNTER_WIDTH-1:0] stall_q, stall_d;
  logic [COUNTER_WIDTH-1:0] flush_q, flush_d;

  logic freeze;
  logic loadUse;
  logic branchWins;
  logic stallEvent;

  always_comb begin
    freeze     = (state_q == ERROR) | (memRequest & ~dataMemoryReady);
    loadUse    = exMemoryReadEnable & exRegisterWriteEnable & (exRd != 5'd0) &
                 ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));
    branchWins = ~freeze & branchTaken;
    stallEvent = freeze | (~branchTaken & loadUse);
  end

  // Priority: freeze > branch > load-use > normal; everything held low during reset.
  always_comb begin
    pcWriteEnable    = 1'b0;
    ifIdWriteEnable  = 1'b0;
    ifIdFlush        = 1'b0;
    idExWriteEnable  = 1'b0;
    idExFlush        = 1'b0;
    exMemWriteEnable = 1'b0;
    memWbWriteEnable = 1'b0;
    if (!reset && !freeze) begin
      pcWriteEnable    = 1'b1;
      ifIdWriteEnable  = 1'b1;
      idExWriteEnable  = 1'b1;
      exMemWriteEnable = 1'b1;
      memWbWriteEnable = 1'b1;
      if (branchTaken) begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
      end else if (loadUse) begin
        pcWriteEnable   = 1'b0;
        ifIdWriteEnable = 1'b0;
        idExFlush       = 1'b1;
      end
    end
  end

  // waitCount holds freeze cycles already completed, so the current cycle is
  // the last allowed one when waitCount equals TIMEOUT_CYCLES-1.
  always_comb begin
    state_d     = state_q;
    waitCount_d = waitCount_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d     = MEM_WAIT;
          waitCount_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d     = RUN;
          waitCount_d = '0;
        end else if (waitCount_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
        end else begin
          waitCount_d = waitCount_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stallEvent && (stall_q != '1)) stall_d = stall_q + COUNTER_WIDTH'(1);
    if (branchWins && (flush_q != '1)) flush_d = flush_q + COUNTER_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      waitCount_q <= '0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      waitCount_q <= waitCount_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign memoryTimeout = (state_q == ERROR);
  assign stallCycles   = stall_q;
  assign flushCount    = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: hazards, freeze/timeout, async reset, saturation.
module tb_hazard_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       exMemoryReadEnable, exRegisterWriteEnable;
  logic [4:0] exRd, idRs1, idRs2;
  logic       idUsesRs1, idUsesRs2, branchTaken, memRequest, dataMemoryReady;

  logic        pcWE, ifIdWE, ifIdFl, idExWE, idExFl, exMemWE, memWbWE, tmo;
  logic [31:0] stallC, flushC;
  logic        s_pcWE, s_ifIdWE, s_ifIdFl, s_idExWE, s_idExFl, s_exMemWE, s_memWbWE, s_tmo;
  logic [3:0]  s_stallC, s_flushC;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clock = ~clock;

  hazard_control_unit #(.TIMEOUT_CYCLES(16), .COUNTER_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .exMemoryReadEnable(exMemoryReadEnable), .exRegisterWriteEnable(exRegisterWriteEnable),
    .exRd(exRd), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .branchTaken(branchTaken), .memRequest(memRequest), .dataMemoryReady(dataMemoryReady),
    .pcWriteEnable(pcWE), .ifIdWriteEnable(ifIdWE), .ifIdFlush(ifIdFl),
    .idExWriteEnable(idExWE), .idExFlush(idExFl), .exMemWriteEnable(exMemWE),
    .memWbWriteEnable(memWbWE), .memoryTimeout(tmo), .stallCycles(stallC), .flushCount(flushC)
  );

  hazard_control_unit #(.TIMEOUT_CYCLES(16), .COUNTER_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset),
    .exMemoryReadEnable(exMemoryReadEnable), .exRegisterWriteEnable(exRegisterWriteEnable),
    .exRd(exRd), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .branchTaken(branchTaken), .memRequest(memRequest), .dataMemoryReady(dataMemoryReady),
    .pcWriteEnable(s_pcWE), .ifIdWriteEnable(s_ifIdWE), .ifIdFlush(s_ifIdFl),
    .idExWriteEnable(s_idExWE), .idExFlush(s_idExFl), .exMemWriteEnable(s_exMemWE),
    .memWbWriteEnable(s_memWbWE), .memoryTimeout(s_tmo), .stallCycles(s_stallC),
    .flushCount(s_flushC)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Packs {pc, ifId, ifIdFlush, idEx, idExFlush, exMem, memWb}
  function automatic logic [6:0] ctl();
    return {pcWE, ifIdWE, ifIdFl, idExWE, idExFl, exMemWE, memWbWE};
  endfunction

  task automatic idle();
    exMemoryReadEnable = 0; exRegisterWriteEnable = 0; exRd = 0;
    idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
    branchTaken = 0; memRequest = 0; dataMemoryReady = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    exMemoryReadEnable = 1; exRegisterWriteEnable = 1; exRd = rd;
    idRs1 = 5; idUsesRs1 = 1;
  endtask

  // Inputs change 1 time unit after the rising edge; sampling happens 1 later.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    load_use(5'd5);
    #2;
    chk("reset_ctl", 32'(ctl()), 32'h0);
    chk("reset_tmo", 32'(tmo), 0);
    chk("reset_stall", stallC, 0);
    chk("reset_flush", flushC, 0);
    cyc();
    idle();
    reset = 0;
    #1;
    chk("normal_ctl", 32'(ctl()), 32'b1101011);
    cyc();

    // Load-use on rs1
    load_use(5'd5);
    #1;
    chk("lu_ctl", 32'(ctl()), 32'b0001111);
    cyc();
    idle();
    chk("lu_stall", stallC, 1);

    // Load-use with exRd==0 and on rs2
    load_use(5'd0); idRs1 = 0;
    #1;
    chk("lu_x0_ctl", 32'(ctl()), 32'b1101011);
    cyc();
    chk("lu_x0_stall", stallC, 1);
    idle();
    exMemoryReadEnable = 1; exRegisterWriteEnable = 1; exRd = 9; idRs2 = 9; idUsesRs2 = 1;
    #1;
    chk("lu_rs2_pc", 32'(pcWE), 0);
    idUsesRs2 = 0;
    #1;
    chk("lu_rs2_unused_pc", 32'(pcWE), 1);
    idUsesRs2 = 1;
    cyc();
    chk("lu_rs2_stall", stallC, 2);
    idle();

    // Branch beats load-use
    load_use(5'd5); branchTaken = 1;
    #1;
    chk("br_ctl", 32'(ctl()), 32'b1111111);
    cyc();
    idle();
    chk("br_flush", flushC, 1);
    chk("br_stall", stallC, 2);

    // Memory wait 3 cycles, branch ignored while frozen
    memRequest = 1; dataMemoryReady = 0;
    for (int i = 0; i < 3; i++) begin
      branchTaken = (i == 1);
      #1;
      chk("mw_ctl", 32'(ctl()), 32'h0);
      cyc();
    end
    branchTaken = 0;
    dataMemoryReady = 1;
    #1;
    chk("mw_release_ctl", 32'(ctl()), 32'b1101011);
    cyc();
    idle();
    chk("mw_stall", stallC, 5);
    chk("mw_flush", flushC, 1);
    chk("mw_tmo", 32'(tmo), 0);

    // Ready pulse restarts the watchdog: 10 low, 1 high, 10 low
    memRequest = 1;
    for (int i = 0; i < 21; i++) begin
      dataMemoryReady = (i == 10);
      cyc();
    end
    dataMemoryReady = 1;
    cyc();
    chk("restart_tmo", 32'(tmo), 0);
    chk("restart_stall", stallC, 25);

    // Boundary: 15 frozen cycles, ready arrives in cycle 16
    dataMemoryReady = 0;
    for (int i = 0; i < 15; i++) cyc();
    dataMemoryReady = 1;
    #1;
    chk("bound_ctl", 32'(ctl()), 32'b1101011);
    cyc();
    chk("bound_tmo", 32'(tmo), 0);

    // Timeout: 16 frozen cycles
    dataMemoryReady = 0;
    for (int i = 0; i < 15; i++) cyc();
    chk("pre_tmo", 32'(tmo), 0);
    cyc();
    chk("tmo_set", 32'(tmo), 1);
    idle();
    #1;
    chk("tmo_ctl_stuck", 32'(ctl()), 32'h0);
    cyc();
    chk("tmo_sticky", 32'(tmo), 1);

    // Asynchronous reset between edges
    #2;
    reset = 1;
    #1;
    chk("areset_tmo", 32'(tmo), 0);
    chk("areset_stall", stallC, 0);
    chk("areset_flush", flushC, 0);
    chk("areset_ctl", 32'(ctl()), 32'h0);
    cyc();
    #2;
    reset = 0;
    #1;
    chk("post_reset_ctl", 32'(ctl()), 32'b1101011);
    cyc();

    // Saturation: 20 consecutive load-use cycles
    load_use(5'd5);
    for (int i = 0; i < 20; i++) cyc();
    idle();
    chk("sat4_stall", 32'(s_stallC), 15);
    chk("wide_stall", stallC, 20);
    cyc();
    chk("sat4_hold", 32'(s_stallC), 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
